// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared state encoding and default operand width for the
//                bit-serial adder controller.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_add_pkg;

    // Default operand/sum width in bits
    localparam int c_DEFAULT_WIDTH = 4;

    // Controller states, explicitly 2-bit encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit combinational full adder.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller. Accepts a, b and ci on start,
//                adds one bit per cycle through a single full adder, and
//                presents the registered sum and carry-out with a one-cycle
//                done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Bit counter spans 0..WIDTH-1 and never needs to reach WIDTH
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_psum;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;
    logic               r_busy;
    logic               r_done;
    logic               w_sum_bit;
    logic               w_carry_bit;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST_BIT);

    full_adder u_full_adder (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_sum_bit),
        .co (w_carry_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE always falls back to IDLE after one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, serial shift/add, result load, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Flags are decoded from the next state so they align with it
            r_busy <= (w_state_next == RUN);
            r_done <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_bit;
                    r_psum  <= {w_sum_bit, r_psum[WIDTH-1:1]};
                    if (w_last) begin
                        // Final bit: the result registers see the full sum now
                        r_s  <= {w_sum_bit, r_psum[WIDTH-1:1]};
                        r_co <= w_carry_bit;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl at WIDTH=4. Expected
//                results come from plain integer addition and cycle counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int total;
    int bad;
    logic [W:0] held;   // {co, s} the outputs should currently hold

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, WIDTH busy cycles, one done cycle, idle.
    // Operands and start are scrambled after acceptance; none may matter.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci);
        logic [W:0] exp;
        exp   = (W+1)'(oa) + (W+1)'(ob) + (W+1)'(oci);
        a     = oa;
        b     = ob;
        ci    = oci;
        start = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            ci    = 1'($urandom);
            start = 1'($urandom);
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_hold", 32'({co, s}), 32'(held));
            tick();
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("sum", 32'({co, s}), 32'(exp));
        held = exp;
        tick();
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hold", 32'({co, s}), 32'(held));
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] exp;
        total = 0;
        bad   = 0;
        held  = '0;
        rst   = 1'b1;
        start = 1'b1;
        a     = '1;
        b     = '1;
        ci    = 1'b1;

        // Reset dominates a pending start
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'({co, s}), 32'd0);

        // First cycle after reset release accepts start
        rst = 1'b0;
        do_op(4'b1010, 4'b0101, 1'b0);
        do_op(4'b1111, 4'b0001, 1'b1);
        do_op(4'b0100, 4'b0111, 1'b1);

        // Start held high with operands changing every cycle: period W+2
        start = 1'b1;
        for (int n = 0; n < 4 * (W + 2); n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            if (n % (W + 2) == 0) q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(ci));
            tick();
            if (n % (W + 2) < W) begin
                check("cont_busy", 32'(busy), 32'd1);
                check("cont_done", 32'(done), 32'd0);
            end else if (n % (W + 2) == W) begin
                exp = q.pop_front();
                check("cont_done", 32'(done), 32'd1);
                check("cont_sum", 32'({co, s}), 32'(exp));
                held = exp;
            end else begin
                check("cont_idle", 32'({busy, done}), 32'd0);
            end
        end
        start = 1'b0;
        tick();

        // Reset in the second RUN cycle aborts with no done pulse
        a     = 4'b1001;
        b     = 4'b0111;
        ci    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_run1", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'({co, s}), 32'd0);
        held = '0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("abort_nodone", 32'({busy, done}), 32'd0);
        end
        do_op(4'b0011, 4'b0010, 1'b0);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            do_op(W'(i >> 5), W'(i >> 1), 1'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; all ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; sampled when start is accepted
- b  input  WIDTH  operand B; sampled when start is accepted
- ci  input  1  carry-in; sampled when start is accepted
- busy  output  1  high while the bit-serial addition is in progress
- done  output  1  single-cycle pulse; s and co valid
- s  output  WIDTH  registered sum
- co  output  1  registered carry-out

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-004 IDLE with start=1 at a clock edge SHALL:
- latch a, b and ci into internal shift and carry registers;
- clear the bit counter to 0;
- move to RUN.
REQ-005 IDLE with start=0 SHALL remain in IDLE.
REQ-006 Each RUN cycle SHALL pass the current LSBs of the A/B shift registers and the carry register through one 1-bit full adder.
REQ-007 Each RUN cycle SHALL shift the sum bit into the MSB of the partial-sum register, shift the A/B registers right by one, and update the carry register with the adder carry.
REQ-008 RUN SHALL last exactly WIDTH cycles; at the edge where bit counter = WIDTH-1 the FSM SHALL move to DONE.
REQ-009 On entry to DONE, s SHALL load the complete partial sum and co SHALL load the final carry.
REQ-010 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-011 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both SHALL be registered state decodes.
REQ-012 Latency: start accepted at edge k SHALL give busy high for cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1, and the next start accepted no earlier than edge k+WIDTH+2.
REQ-013 s and co SHALL hold their value from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-014 start in RUN or DONE SHALL be ignored; no queuing and no effect on the operation in progress.
REQ-015 Changes on a, b or ci after acceptance SHALL NOT affect the result.
REQ-016 Arithmetic: {co, s} SHALL equal a + b + ci, computed at WIDTH+1 bits, for all inputs; co=1 exactly on unsigned overflow.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within RUN.

Reset
REQ-018 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, s=0, co=0, and clear the counter, shift registers and carry register.
REQ-019 rst SHALL take priority over start and over any state transition.
REQ-020 rst asserted mid-RUN SHALL abort the operation with no done pulse; s and co SHALL read 0 afterwards.
REQ-021 The first start after rst deasserts SHALL be accepted in the first cycle with rst=0.

Structure
REQ-022 A shared package serial_add_pkg SHALL hold the IDLE/RUN/DONE state encoding (2-bit typedef) and the default WIDTH constant.
REQ-023 The 1-bit combinational adder SHALL be a separate sub-module full_adder (ports a, b, ci, s, co), instantiated once.
REQ-024 All other logic (FSM, counter, shift registers, output registers) SHALL reside in serial_add_ctrl.

Verification (WIDTH=4)
REQ-025 The bench SHALL drive a=1010, b=0101, ci=0, start pulsed at edge k -> busy high for cycles k+1..k+4; done high in cycle k+5 only; s=1111, co=0.
REQ-026 The bench SHALL drive a=1111, b=0001, ci=1 -> s=0001, co=1; and a=0100, b=0111, ci=1 -> s=1100, co=0.
REQ-027 The bench SHALL hold start high continuously, with a/b changed every cycle -> one operation per 6 cycles; each result matches the operands sampled at its accepting edge.
REQ-028 The bench SHALL assert rst for one cycle at the second RUN cycle -> no done pulse; busy=0, s=0, co=0 in the next cycle; a following start with 0011+0010, ci=0 -> s=0101, co=0.
REQ-029 The bench SHALL run an exhaustive sweep of all a, b, ci (512 cases) against a+b+ci -> zero mismatches, with done pulse width of exactly 1 cycle in every case.
